// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared request/response types and widths for unified_memory_arbiter
package mem_arb_pkg;
  localparam int NB_COL_DEF = 4;
  localparam int WORD_W = NB_COL_DEF * 8;
  typedef struct packed {
    logic                    we;
    logic [31:0]             addr;
    logic [NB_COL_DEF-1:0]   be;
    logic [WORD_W-1:0]       wdata;
  } mem_req_t;
  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } resp_tag_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; valid in, one-hot grant out, rr_q flips to the loser on accept
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic rr_q;
  always_comb grant = (valid == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : valid;
  always_ff @(posedge clk_i)
    if (rst_i) rr_q <= 1'b0;
    else if (accept) rr_q <= ~grant[1];
endmodule

// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: round-robin share of memory port B between two requesters with tagged, fixed-latency responses
module unified_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RAM_DEPTH    = 512,
  parameter int NB_COL       = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   req_valid_i,
  output logic [1:0]                   req_ready_o,
  input  logic [1:0]                   req_we_i,
  input  logic [63:0]                  req_addr_i,
  input  logic [2*NB_COL-1:0]          req_be_i,
  input  logic [2*NB_COL*8-1:0]        req_wdata_i,
  output logic [1:0]                   resp_valid_o,
  output logic [1:0]                   resp_err_o,
  output logic [NB_COL*8-1:0]          resp_rdata_o,
  output logic                         mem_en_o,
  output logic [NB_COL-1:0]            mem_we_o,
  output logic [$clog2(RAM_DEPTH)-1:0] mem_addr_o,
  output logic [NB_COL*8-1:0]          mem_din_o,
  output logic                         mem_regce_o,
  output logic                         mem_rst_o,
  input  logic [NB_COL*8-1:0]          mem_dout_i
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int DW = NB_COL * 8;
  logic [1:0] grant;
  logic       accept;
  logic       id;
  logic       in_range;
  logic       unused_addr_lsbs;
  mem_req_t   req;
  resp_tag_t  tag_q [READ_LATENCY];
  resp_tag_t  last;
  rr_arbiter2 u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid  (req_valid_i),
    .accept (accept),
    .grant  (grant)
  );
  always_comb begin
    req_ready_o = rst_i ? 2'b00 : grant;
    accept      = |req_ready_o;
    id          = req_ready_o[1];
    req.we      = id ? req_we_i[1] : req_we_i[0];
    req.addr    = id ? req_addr_i[63:32] : req_addr_i[31:0];
    req.be      = id ? req_be_i[2*NB_COL-1:NB_COL] : req_be_i[NB_COL-1:0];
    req.wdata   = id ? req_wdata_i[2*DW-1:DW] : req_wdata_i[DW-1:0];
    in_range    = {2'b00, req.addr[31:2]} < 32'(RAM_DEPTH);
    mem_en_o    = accept & in_range;
    mem_we_o    = (mem_en_o & req.we) ? req.be : '0;
    mem_addr_o  = req.addr[AW+1:2];
    mem_din_o   = req.wdata;
    mem_regce_o = 1'b1;
    mem_rst_o   = rst_i;
    unused_addr_lsbs = ^req.addr[1:0];
  end
  always_ff @(posedge clk_i)
    if (rst_i) tag_q <= '{default: '0};
    else begin
      tag_q[0] <= '{valid: accept, id: id, err: accept & ~in_range};
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  always_comb begin
    last         = tag_q[READ_LATENCY-1];
    resp_valid_o = last.valid ? (last.id ? 2'b10 : 2'b01) : 2'b00;
    resp_err_o   = (last.valid & last.err) ? (last.id ? 2'b10 : 2'b01) : 2'b00;
    resp_rdata_o = (last.valid & ~last.err) ? mem_dout_i : '0;
  end
endmodule
